pipelined_mul: RTL and testbench

PIPELINED_MUL -- requirements
Module: pipelined_mul

---
 rtl/mul_pkg.sv | 41 ++++
 rtl/mul_pipe_stage.sv | 35 +++
 rtl/pipelined_mul.sv | 145 ++++++++++++++
 tb/tb_pipelined_mul.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared constants and saturation bound helpers for pipelined_mul.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Operand / result width
  localparam int WIDTH_DEFAULT   = 8;
  localparam int WIDTH_MIN       = 2;
  localparam int WIDTH_MAX       = 32;

  // Input-to-output latency in cycles (one register stage per cycle)
  localparam int LATENCY_DEFAULT = 3;
  localparam int LATENCY_MIN     = 1;
  localparam int LATENCY_MAX     = 8;

  // Widest product the clamp logic ever has to compare (2 * WIDTH_MAX)
  localparam int PROD_MAX_BITS   = 64;

  typedef logic        [PROD_MAX_BITS-1:0] wide_u_t;
  typedef logic signed [PROD_MAX_BITS-1:0] wide_s_t;

  // Largest unsigned value representable in w bits: 2^w - 1
  function automatic wide_u_t sat_umax(input int unsigned w);
    return (wide_u_t'(1) << w) - wide_u_t'(1);
  endfunction

  // Largest signed value representable in w bits: 2^(w-1) - 1
  function automatic wide_s_t sat_smax(input int unsigned w);
    return $signed((wide_u_t'(1) << (w - 1)) - wide_u_t'(1));
  endfunction

  // Smallest signed value representable in w bits: -2^(w-1)
  function automatic wide_s_t sat_smin(input int unsigned w);
    return -$signed(wide_u_t'(1) << (w - 1));
  endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe_stage
// Purpose  : One register stage of the multiplier pipeline: a data register
//            plus its valid flag, both advancing only when en is high.
// Revision : 1.0 - initial release
// ============================================================================
module mul_pipe_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Stage register: cleared by reset, loads the previous stage when enabled,
  // otherwise holds so a stalled result stays put.
  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule : mul_pipe_stage
`default_nettype wire

// File: rtl/pipelined_mul.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mul
// Purpose  : Valid/ready multiplier. The product is formed combinationally,
//            then delayed through LATENCY register stages. The whole pipe
//            advances together whenever the output slot is empty or being
//            taken, so there is no internal bubble collapsing.
// Config   : MUL_SATURATE_EN - when defined, the result is the full product
//            clamped to the WIDTH-bit range instead of the wrapped low bits.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_mul
  import mul_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int SIGNED  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready
);

  localparam int PW = 2 * WIDTH;

  // --------------------------------------------------------------------------
  // Parameter legality, reported while elaborating
  // --------------------------------------------------------------------------
  generate
    if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
      $error("pipelined_mul: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
      $error("pipelined_mul: LATENCY=%0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end
    if ((SIGNED != 0) && (SIGNED != 1)) begin : g_bad_signed
      $error("pipelined_mul: SIGNED=%0d must be 0 or 1", SIGNED);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Full-width product
  // --------------------------------------------------------------------------
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] res;

  generate
    if (SIGNED != 0) begin : g_mul_signed
      // Size-casting a signed operand sign-extends it, so the PW-bit product
      // is the exact two's-complement result.
      assign prod = PW'($signed(I0)) * PW'($signed(I1));
    end else begin : g_mul_unsigned
      assign prod = PW'(I0) * PW'(I1);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Result selection ahead of stage 0 (clamp or wrap)
  // --------------------------------------------------------------------------
`ifdef MUL_SATURATE_EN
  generate
    if (SIGNED != 0) begin : g_sat_signed
      localparam wide_s_t SMAX = sat_smax(WIDTH);
      localparam wide_s_t SMIN = sat_smin(WIDTH);
      wide_s_t prod_wide;

      assign prod_wide = PROD_MAX_BITS'($signed(prod));

      // Clamp the signed product into [-2^(W-1), 2^(W-1)-1].
      always_comb begin
        res = prod[WIDTH-1:0];
        if (prod_wide > SMAX) begin
          res = SMAX[WIDTH-1:0];
        end else if (prod_wide < SMIN) begin
          res = SMIN[WIDTH-1:0];
        end
      end
    end else begin : g_sat_unsigned
      localparam wide_u_t UMAX = sat_umax(WIDTH);
      wide_u_t prod_wide;

      assign prod_wide = PROD_MAX_BITS'(prod);

      // Clamp the unsigned product to 2^W-1.
      always_comb begin
        res = prod[WIDTH-1:0];
        if (prod_wide > UMAX) begin
          res = UMAX[WIDTH-1:0];
        end
      end
    end
  endgenerate
`else
  // Wrapping result: the low half of the product, identical for either
  // signedness. The upper half is intentionally discarded.
  logic unused_prod_hi;

  assign res            = prod[WIDTH-1:0];
  assign unused_prod_hi = ^prod[PW-1:WIDTH];
`endif

  // --------------------------------------------------------------------------
  // Handshake and stage chain
  // --------------------------------------------------------------------------
  logic             adv;
  logic [WIDTH-1:0] stage_d [LATENCY+1];
  logic             stage_v [LATENCY+1];

  assign stage_d[0] = res;
  assign stage_v[0] = I_valid;

  // The pipe moves when the output slot is empty or is being accepted.
  assign adv     = !O_valid || O_ready;
  assign I_ready = adv;

  generate
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      mul_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clock   (clock),
        .reset   (reset),
        .en      (adv),
        .d       (stage_d[k]),
        .d_valid (stage_v[k]),
        .q       (stage_d[k+1]),
        .q_valid (stage_v[k+1])
      );
    end
  endgenerate

  // The last stage is the output. While reset is being sampled the valid is
  // masked, so an in-flight result that is about to be flushed is never
  // presented as a transfer.
  assign O       = stage_d[LATENCY];
  assign O_valid = stage_v[LATENCY] && !reset;

endmodule : pipelined_mul
`default_nettype wire

// File: tb/tb_pipelined_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_mul
// Purpose  : Directed self-checking bench for pipelined_mul. Four instances:
//            default unsigned (A), signed (S), LATENCY=1 and LATENCY=8 sweeps.
// Config   : honours MUL_SATURATE_EN for the expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_mul;

`ifdef MUL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clock;
  logic reset;

  // Instance A: defaults
  logic [7:0] a_i0, a_i1, a_o;
  logic       a_iv, a_irdy, a_ov, a_ordy;
  // Instance S: signed, WIDTH 8, LATENCY 3
  logic [7:0] s_i0, s_i1, s_o;
  logic       s_iv, s_irdy, s_ov, s_ordy;
  // Sweep instances: [0] LATENCY=1, [1] LATENCY=8
  logic [1:0][7:0] w_i0, w_i1, w_o;
  logic [1:0]      w_iv, w_irdy, w_ov, w_ordy;

  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];

  int total = 0;
  int bad   = 0;

  pipelined_mul dut_a (
    .clock(clock), .reset(reset), .I0(a_i0), .I1(a_i1), .I_valid(a_iv),
    .I_ready(a_irdy), .O(a_o), .O_valid(a_ov), .O_ready(a_ordy)
  );

  pipelined_mul #(.WIDTH(8), .LATENCY(3), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .I0(s_i0), .I1(s_i1), .I_valid(s_iv),
    .I_ready(s_irdy), .O(s_o), .O_valid(s_ov), .O_ready(s_ordy)
  );

  pipelined_mul #(.WIDTH(8), .LATENCY(1), .SIGNED(0)) dut_l1 (
    .clock(clock), .reset(reset), .I0(w_i0[0]), .I1(w_i1[0]), .I_valid(w_iv[0]),
    .I_ready(w_irdy[0]), .O(w_o[0]), .O_valid(w_ov[0]), .O_ready(w_ordy[0])
  );

  pipelined_mul #(.WIDTH(8), .LATENCY(8), .SIGNED(0)) dut_l8 (
    .clock(clock), .reset(reset), .I0(w_i0[1]), .I1(w_i1[1]), .I_valid(w_iv[1]),
    .I_ready(w_irdy[1]), .O(w_o[1]), .O_valid(w_ov[1]), .O_ready(w_ordy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference for the unsigned 8-bit sweeps
  function automatic logic [7:0] model_u8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = 16'(x) * 16'(y);
    if (SAT && (p > 16'd255)) return 8'hFF;
    return p[7:0];
  endfunction

  // Single pair through instance A, result checked exactly at cycle 3
  task automatic a_pulse(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp);
    a_i0 = x; a_i1 = y; a_iv = 1'b1; a_ordy = 1'b1;
    step();
    a_iv = 1'b0;
    step();
    step();
    check({tag, "_v"}, 64'(a_ov), 64'd1);
    check(tag, 64'(a_o), 64'(exp));
    step();
  endtask

  // Single pair through instance S, result checked exactly at cycle 3
  task automatic s_pulse(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp);
    s_i0 = x; s_i1 = y; s_iv = 1'b1; s_ordy = 1'b1;
    step();
    s_iv = 1'b0;
    step();
    step();
    check({tag, "_v"}, 64'(s_ov), 64'd1);
    check(tag, 64'(s_o), 64'(exp));
    step();
  endtask

  initial begin
    int         nxt;
    int         got;
    logic       stalled;
    logic [7:0] held;
    logic [7:0] e;

    reset = 1'b1;
    a_i0 = '0; a_i1 = '0; a_iv = 1'b0; a_ordy = 1'b1;
    s_i0 = '0; s_i1 = '0; s_iv = 1'b0; s_ordy = 1'b1;
    w_i0 = '0; w_i1 = '0; w_iv = '0;   w_ordy = '1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_ovalid", 64'(a_ov), 64'd0);
    check("rst_o", 64'(a_o), 64'd0);
    check("rst_iready", 64'(a_irdy), 64'd1);

    // 7*6 pulsed at cycle 0: valid at cycle 3 only
    a_i0 = 8'd7; a_i1 = 8'd6; a_iv = 1'b1; a_ordy = 1'b1;
    step();
    a_iv = 1'b0;
    check("lat_c1", 64'(a_ov), 64'd0);
    step();
    check("lat_c2", 64'(a_ov), 64'd0);
    step();
    check("lat_c3_v", 64'(a_ov), 64'd1);
    check("lat_c3_o", 64'(a_o), 64'd42);
    step();
    check("lat_c4", 64'(a_ov), 64'd0);

    // Unsigned boundaries: 400, 65025, 255, 256
    a_pulse("u_200x2",   8'd200, 8'd2,   SAT ? 8'hFF : 8'd144);
    a_pulse("u_255x255", 8'd255, 8'd255, SAT ? 8'hFF : 8'h01);
    a_pulse("u_15x17",   8'd15,  8'd17,  8'hFF);
    a_pulse("u_16x16",   8'd16,  8'd16,  SAT ? 8'hFF : 8'h00);

    // Signed: -15, -200, +200, -128*1
    s_pulse("s_m3x5",    8'hFD, 8'd5,  8'hF1);
    s_pulse("s_m100x2",  8'h9C, 8'd2,  SAT ? 8'h80 : 8'h38);
    s_pulse("s_100x2",   8'd100, 8'd2, SAT ? 8'h7F : 8'hC8);
    s_pulse("s_m128x1",  8'h80, 8'd1,  8'h80);

    // Back-to-back 1*1..10*10 with downstream stalled in cycles 4..7
    nxt = 1; got = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      a_ordy = !((c >= 4) && (c <= 7));
      a_iv   = (nxt <= 10);
      a_i0   = 8'(nxt);
      a_i1   = 8'(nxt);
      #1;
      if ((c >= 4) && (c <= 7)) check("stall_iready", 64'(a_irdy), 64'd0);
      if (stalled) begin
        check("stall_hold_v", 64'(a_ov), 64'd1);
        check("stall_hold_o", 64'(a_o), 64'(held));
      end
      if (a_ov && a_ordy) begin
        got++;
        check("stream_o", 64'(a_o), 64'(got * got));
      end
      stalled = a_ov && !a_ordy;
      held    = a_o;
      if (a_iv && a_irdy) nxt++;
      step();
    end
    a_iv = 1'b0; a_ordy = 1'b1;
    check("stream_count", 64'(got), 64'd10);
    step();
    check("stream_nodup1", 64'(a_ov), 64'd0);
    step();
    check("stream_nodup2", 64'(a_ov), 64'd0);

    // Random valid/ready sweeps on LATENCY=1 and LATENCY=8 with a reset at cycle 5
    for (int c = 0; c < 80; c++) begin
      reset = (c == 5);
      for (int j = 0; j < 2; j++) begin
        w_iv[j]   = (c < 64) ? 1'($urandom_range(0, 1)) : 1'b0;
        w_ordy[j] = (c >= 66) ? 1'b1 : ($urandom_range(0, 3) != 0);
        w_i0[j]   = 8'($urandom);
        w_i1[j]   = 8'($urandom);
      end
      #1;
      if (c == 5) begin
        check("rst_mid_v_l1", 64'(w_ov[0]), 64'd0);
        check("rst_mid_v_l8", 64'(w_ov[1]), 64'd0);
      end
      if (c == 6) begin
        check("flush_v_l1", 64'(w_ov[0]), 64'd0);
        check("flush_o_l1", 64'(w_o[0]),  64'd0);
        check("flush_v_l8", 64'(w_ov[1]), 64'd0);
        check("flush_o_l8", 64'(w_o[1]),  64'd0);
      end
      if (reset) begin
        sb0.delete();
        sb1.delete();
      end else begin
        for (int j = 0; j < 2; j++) begin
          if (w_ov[j] && w_ordy[j]) begin
            if (((j == 0) ? sb0.size() : sb1.size()) == 0) begin
              check(j == 0 ? "sb_extra_l1" : "sb_extra_l8", 64'd1, 64'd0);
            end else begin
              e = (j == 0) ? sb0.pop_front() : sb1.pop_front();
              check(j == 0 ? "sweep_l1" : "sweep_l8", 64'(w_o[j]), 64'(e));
            end
          end
          if (w_iv[j] && w_irdy[j]) begin
            if (j == 0) sb0.push_back(model_u8(w_i0[j], w_i1[j]));
            else        sb1.push_back(model_u8(w_i0[j], w_i1[j]));
          end
        end
      end
      step();
    end
    reset = 1'b0;
    check("drain_l1", 64'(sb0.size()), 64'd0);
    check("drain_l8", 64'(sb1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipelined_mul
`default_nettype wire
